// File: rtl/mem_requester_pkg.sv
// Shared types and helpers for the mem_requester memory initiator.
// Imported by the interface, the top and the optional statistics block.
package mem_requester_pkg;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      IDLE    = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   localparam int STAT_W = 16;

   function automatic logic in_range(input int unsigned addr, input int unsigned size);
      return addr < size;
   endfunction

endpackage

// File: rtl/mem_requester_if.sv
// Command/response handshake plus memory strobe bus of mem_requester.
// Handshake: a transfer happens on a rising clock edge where valid && ready;
// the sender holds valid and payload stable until then, and ready may depend on valid.
interface mem_requester_if #(
   parameter int DATA_W    = 8,
   parameter int ADDR_SIZE = 3
);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_we;
   logic [ADDR_SIZE-1:0] cmd_addr;
   logic [DATA_W-1:0]    cmd_wdata;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DATA_W-1:0]    rsp_data;
   logic                 rsp_err;

   logic                 mem_write;
   logic                 mem_read;
   logic [ADDR_SIZE-1:0] mem_addr_w;
   logic [ADDR_SIZE-1:0] mem_addr_r;
   logic [DATA_W-1:0]    mem_datain;
   logic [DATA_W-1:0]    mem_dataout;

   // The requester side: takes commands, returns responses, drives the memory.
   modport slave (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, mem_dataout,
      output cmd_ready, rsp_valid, rsp_data, rsp_err,
             mem_write, mem_read, mem_addr_w, mem_addr_r, mem_datain
   );

   // The environment side: command source, response sink and memory.
   modport master (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, mem_dataout,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err,
             mem_write, mem_read, mem_addr_w, mem_addr_r, mem_datain
   );

endinterface

// File: rtl/mem_requester_stats.sv
// Saturating 16-bit event counters for accepted writes, reads and
// out-of-range commands; only instantiated under MEM_REQUESTER_STATS_EN.
module mem_requester_stats
   import mem_requester_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              inc_wr,
   input  logic              inc_rd,
   input  logic              inc_err,
   output logic [STAT_W-1:0] stat_wr,
   output logic [STAT_W-1:0] stat_rd,
   output logic [STAT_W-1:0] stat_err
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_wr  <= '0;
         stat_rd  <= '0;
         stat_err <= '0;
      end else begin
         if (inc_wr && (stat_wr != '1))
            stat_wr <= stat_wr + 1'b1;
         if (inc_rd && (stat_rd != '1))
            stat_rd <= stat_rd + 1'b1;
         if (inc_err && (stat_err != '1))
            stat_err <= stat_err + 1'b1;
      end
   end

endmodule

// File: rtl/mem_requester.sv
// Memory initiator: sweeps memory to INIT_VALUE after reset, then serves one
// command at a time. Optional counters under MEM_REQUESTER_STATS_EN.
module mem_requester
   import mem_requester_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                MEM_SIZE   = 6,
   parameter int                ADDR_SIZE  = $clog2(MEM_SIZE),
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic              clock,
   input  logic              reset,
   mem_requester_if.slave    bus,
   output state_t            dbg_state
`ifdef MEM_REQUESTER_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_wr,
   output logic [STAT_W-1:0] stat_rd,
   output logic [STAT_W-1:0] stat_err
`endif
);

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);

   state_t               state, state_nxt;
   logic [ADDR_SIZE-1:0] cnt;
   logic                 rsp_valid_q;
   logic                 rsp_err_q;
   logic [DATA_W-1:0]    rsp_data_q;
   logic                 cmd_ready_c;
   logic                 accept;
   logic                 addr_ok;

   // Ready only when the response slot is empty or being drained this cycle.
   assign cmd_ready_c = (state == IDLE) && (!rsp_valid_q || bus.rsp_ready);
   assign accept      = bus.cmd_valid && cmd_ready_c;
   assign addr_ok     = in_range(32'(bus.cmd_addr), 32'(MEM_SIZE));

   assign bus.cmd_ready = cmd_ready_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign dbg_state     = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT)
            cnt <= (cnt == LAST_ADDR) ? '0 : cnt + 1'b1;
      end
   end

   // Strobes are gated by reset because the async reset parks the FSM in INIT,
   // which would otherwise assert mem_write while reset is still high.
   always_comb begin
      state_nxt      = state;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_addr_w = '0;
      bus.mem_addr_r = '0;
      bus.mem_datain = '0;
      case (state)
         INIT: begin
            if (!reset) begin
               bus.mem_write  = 1'b1;
               bus.mem_addr_w = cnt;
               bus.mem_datain = INIT_VALUE;
            end
            if (cnt == LAST_ADDR)
               state_nxt = IDLE;
         end
         IDLE: begin
            if (accept && addr_ok) begin
               if (bus.cmd_we) begin
                  bus.mem_write  = 1'b1;
                  bus.mem_addr_w = bus.cmd_addr;
                  bus.mem_datain = bus.cmd_wdata;
               end else begin
                  bus.mem_read   = 1'b1;
                  bus.mem_addr_r = bus.cmd_addr;
                  state_nxt      = RD_WAIT;
               end
            end
         end
         RD_WAIT: state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   // Response register: drain first, then load from this cycle's accept or read return.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
         end
         if (accept && (bus.cmd_we || !addr_ok)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !addr_ok;
            rsp_data_q  <= '0;
         end else if (state == RD_WAIT) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= bus.mem_dataout;
         end
      end
   end

`ifdef MEM_REQUESTER_STATS_EN
   mem_requester_stats u_stats (
      .clock    (clock),
      .reset    (reset),
      .inc_wr   (accept && addr_ok && bus.cmd_we),
      .inc_rd   (accept && addr_ok && !bus.cmd_we),
      .inc_err  (accept && !addr_ok),
      .stat_wr  (stat_wr),
      .stat_rd  (stat_rd),
      .stat_err (stat_err)
   );
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester with MEM_SIZE=6, INIT_VALUE=8'hA5 and a behavioural
// memory with one-cycle registered read data.
module tb_mem_requester;
   import mem_requester_pkg::*;

   localparam int DW = 8;
   localparam int AW = 3;

   logic   clock;
   logic   reset;
   state_t dbg_state;
   int     checks   = 0;
   int     failures = 0;
   logic [AW-1:0] exp_q[$];
   logic [DW-1:0] mem_model [8];
   logic [DW-1:0] rd_q;

`ifdef MEM_REQUESTER_STATS_EN
   logic [STAT_W-1:0] stat_wr, stat_rd, stat_err;
`endif

   mem_requester_if #(.DATA_W(DW), .ADDR_SIZE(AW)) bus ();

   mem_requester #(
      .DATA_W(DW), .MEM_SIZE(6), .ADDR_SIZE(AW), .INIT_VALUE(8'hA5)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
`ifdef MEM_REQUESTER_STATS_EN
      ,
      .stat_wr   (stat_wr),
      .stat_rd   (stat_rd),
      .stat_err  (stat_err)
`endif
   );

   // ---------------- clock / memory model ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (bus.mem_write) mem_model[bus.mem_addr_w] <= bus.mem_datain;
      if (bus.mem_read)  rd_q <= mem_model[bus.mem_addr_r];
   end
   assign bus.mem_dataout = rd_q;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout actual=none required=event", name);
   endtask

   // Releases reset and follows the sweep: addresses 0..5, then ready.
   task automatic check_sweep();
      for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
      @(negedge clock);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(negedge clock);
            #1;
         end
         check("sweep_mem_write", bus.mem_write, 1);
         check("sweep_mem_read", bus.mem_read, 0);
         check("sweep_addr", bus.mem_addr_w, exp_q.pop_front());
         check("sweep_data", bus.mem_datain, 8'hA5);
         check("sweep_cmd_ready", bus.cmd_ready, 0);
         check("sweep_rsp_valid", bus.rsp_valid, 0);
      end
      @(negedge clock);
      #1;
      check("post_sweep_ready", bus.cmd_ready, 1);
      check("post_sweep_write", bus.mem_write, 0);
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic exp_err, input logic [DW-1:0] exp_data);
      int   n;
      logic ok;
      ok = (addr < 6);
      @(negedge clock);
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = we;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      #1;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (!bus.cmd_ready) begin
         timeout("accept");
         bus.cmd_valid = 1'b0;
         return;
      end
      check("acc_mem_write", bus.mem_write, we && ok);
      check("acc_mem_read", bus.mem_read, !we && ok);
      check("acc_addr_w", bus.mem_addr_w, (we && ok) ? addr : 0);
      check("acc_datain", bus.mem_datain, (we && ok) ? wdata : 0);
      check("acc_addr_r", bus.mem_addr_r, (!we && ok) ? addr : 0);
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      #1;
      n = 1;
      while (!bus.rsp_valid && n < 20) begin
         check("wait_no_strobe", bus.mem_write | bus.mem_read, 0);
         @(negedge clock);
         #1;
         n++;
      end
      if (!bus.rsp_valid) begin
         timeout("response");
         return;
      end
      check("rsp_latency", n, (!we && ok) ? 2 : 1);
      check("rsp_err", bus.rsp_err, exp_err);
      check("rsp_data", bus.rsp_data, exp_data);
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          exp_err;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b1, 3'd2, 8'h3C, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 3'd2, 8'h00, 1'b0, 8'h3C};
      vecs[2] = '{1'b0, 3'd3, 8'h00, 1'b0, 8'hA5};
      vecs[3] = '{1'b0, 3'd6, 8'h00, 1'b1, 8'h00};
      vecs[4] = '{1'b1, 3'd7, 8'hFF, 1'b1, 8'h00};
      vecs[5] = '{1'b1, 3'd5, 8'h5A, 1'b0, 8'h00};
      vecs[6] = '{1'b0, 3'd5, 8'h00, 1'b0, 8'h5A};
      vecs[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'hA5};

      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_cmd_ready", bus.cmd_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_mem_write", bus.mem_write, 0);
      check("rst_mem_read", bus.mem_read, 0);
      check("rst_state", dbg_state, INIT);

      check_sweep();

      for (int i = 0; i < 8; i++)
         send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_data);

      // Backpressure: read response held 5 cycles, then drain plus accept together.
      @(negedge clock);
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = 1'b0;
      bus.cmd_addr  = 3'd2;
      #1;
      check("bp_read_ready", bus.cmd_ready, 1);
      @(negedge clock);
      bus.cmd_we    = 1'b1;
      bus.cmd_addr  = 3'd4;
      bus.cmd_wdata = 8'h77;
      #1;
      check("bp_rdwait_state", dbg_state, RD_WAIT);
      check("bp_rdwait_ready", bus.cmd_ready, 0);
      check("bp_rdwait_valid", bus.rsp_valid, 0);
      @(negedge clock);
      #1;
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_data", bus.rsp_data, 8'h3C);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         #1;
         check("bp_hold_valid", bus.rsp_valid, 1);
         check("bp_hold_data", bus.rsp_data, 8'h3C);
         check("bp_hold_err", bus.rsp_err, 0);
         check("bp_hold_ready", bus.cmd_ready, 0);
         check("bp_hold_write", bus.mem_write, 0);
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", bus.cmd_ready, 1);
      check("bp_release_write", bus.mem_write, 1);
      check("bp_release_addr", bus.mem_addr_w, 3'd4);
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      #1;
      check("b2b_wr_valid", bus.rsp_valid, 1);
      check("b2b_wr_data", bus.rsp_data, 0);
      check("b2b_wr_err", bus.rsp_err, 0);
      @(negedge clock);
      #1;
      check("b2b_drained", bus.rsp_valid, 0);

      send(1'b0, 3'd4, 8'h00, 1'b0, 8'h77);

      // Reset while the read is outstanding.
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = 1'b0;
      bus.cmd_addr  = 3'd5;
      #1;
      check("rr_accept_ready", bus.cmd_ready, 1);
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      #1;
      check("rr_state", dbg_state, RD_WAIT);
      reset = 1'b1;
      #1;
      check("rr_async_valid", bus.rsp_valid, 0);
      check("rr_async_state", dbg_state, INIT);
      check("rr_async_write", bus.mem_write, 0);
      check("rr_async_read", bus.mem_read, 0);
      check("rr_async_ready", bus.cmd_ready, 0);
      @(posedge clock);
      check_sweep();
      check("rr_no_rsp", bus.rsp_valid, 0);

`ifdef MEM_REQUESTER_STATS_EN
      check("stat_wr_reset", stat_wr, 0);
      check("stat_rd_reset", stat_rd, 0);
      check("stat_err_reset", stat_err, 0);
      send(1'b1, 3'd0, 8'h11, 1'b0, 8'h00);
      send(1'b1, 3'd1, 8'h22, 1'b0, 8'h00);
      send(1'b1, 3'd2, 8'h33, 1'b0, 8'h00);
      send(1'b0, 3'd1, 8'h00, 1'b0, 8'h22);
      send(1'b0, 3'd3, 8'h00, 1'b0, 8'hA5);
      send(1'b0, 3'd6, 8'h00, 1'b1, 8'h00);
      check("stat_wr", stat_wr, 3);
      check("stat_rd", stat_rd, 2);
      check("stat_err", stat_err, 1);
`endif

      // Sweep overwrote the earlier 8'h5A at address 5.
      send(1'b0, 3'd5, 8'h00, 1'b0, 8'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Initiator side of the single-port-pair memory interface (write/read strobes, separate write/read addresses, 1-cycle registered read data).
- Accepts commands over valid/ready and drives the memory strobes.
- Returns one response per command over valid/ready.
- After every reset it sweeps the whole memory to a known fill value before accepting traffic.

Parameters:
- DATA_W, 8, data word width
- MEM_SIZE, 6, number of valid words; addresses >= MEM_SIZE are out of range
- ADDR_SIZE, $clog2(MEM_SIZE), address width
- INIT_VALUE, 0, word written to every address during the post-reset sweep

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_SIZE  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  command address was out of range
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_addr_w  out  ADDR_SIZE  memory write address
- mem_addr_r  out  ADDR_SIZE  memory read address
- mem_datain  out  DATA_W  memory write data
- mem_dataout  in  DATA_W  memory read data, valid the cycle after mem_read

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=INIT, init counter=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=0.
- While reset is high, the memory strobes are 0.
- States: INIT, IDLE, RD_WAIT.
- INIT:
  - mem_write=1, mem_addr_w=counter, mem_datain=INIT_VALUE, cmd_ready=0.
  - Counter increments each cycle; after writing MEM_SIZE-1, go to IDLE.
  - The sweep takes exactly MEM_SIZE cycles.
- IDLE:
  - cmd_ready = !rsp_valid | rsp_ready, so the response register is never overwritten.
  - Accepted write, cmd_addr < MEM_SIZE: in the same cycle, mem_write=1, mem_addr_w=cmd_addr, mem_datain=cmd_wdata. Next cycle: rsp_valid=1, rsp_err=0, rsp_data=0. Stay in IDLE.
  - Accepted read, cmd_addr < MEM_SIZE: in the same cycle, mem_read=1, mem_addr_r=cmd_addr. Go to RD_WAIT.
  - Accepted command with cmd_addr >= MEM_SIZE: no memory strobe. Next cycle: rsp_valid=1, rsp_err=1, rsp_data=0.
- RD_WAIT:
  - cmd_ready=0, no strobes.
  - Capture mem_dataout into rsp_data, rsp_err=0, rsp_valid=1; go to IDLE.
  - Read latency from accept to rsp_valid is 2 cycles.
- Response handshake:
  - rsp_valid, rsp_data and rsp_err hold stable until rsp_valid&rsp_ready.
  - Same-cycle consume and new accept is allowed, giving back-to-back responses.
- Throughput: 1 write per cycle; 1 read per 2 cycles.
- Strobe rule: mem_read and mem_write are never high in the same cycle.
- Idle outputs: when a strobe is low, its address and data outputs are 0.
- Ordering: responses return strictly in command order; at most 1 command is outstanding.
- Reset mid-operation (including during INIT or RD_WAIT): drop any pending response and restart the sweep from address 0.
- cmd_valid during INIT is ignored; no accept occurs.

Optional Feature:
- Macro: MEM_REQUESTER_STATS_EN.
- When defined, add three outputs: stat_wr, stat_rd, stat_err, each 16 bits.
  - Count accepted in-range writes, accepted in-range reads, and out-of-range commands.
  - Counters saturate at 16'hFFFF, reset to 0, and ignore INIT sweep writes.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_requester_pkg holds:
  - state enum type (INIT, IDLE, RD_WAIT)
  - STAT_W=16 constant
  - in_range(addr, size) function
- One sub-module, mem_requester_stats: the saturating counters, instantiated only under MEM_REQUESTER_STATS_EN.

Test Plan:
- Reset release, MEM_SIZE=6, INIT_VALUE=8'hA5 -> mem_write high for exactly 6 cycles on addresses 0..5; cmd_ready rises on cycle 7; a read of address 3 returns 8'hA5.
- Write 8'h3C to address 2, then read address 2, rsp_ready held at 1 -> write response rsp_err=0, rsp_data=0; read response rsp_data=8'h3C exactly 2 cycles after the read accept.
- Read address 6 and write address 7 -> no mem_read/mem_write pulse; both responses have rsp_err=1, rsp_data=0.
- rsp_ready=0 for 5 cycles after a read -> rsp_valid/rsp_data stable; cmd_ready=0 throughout; next command accepted in the cycle rsp_ready=1.
- Assert reset while in RD_WAIT -> rsp_valid=0 immediately (async); sweep restarts at address 0; the outstanding read produces no response.
- With MEM_REQUESTER_STATS_EN: 3 in-range writes, 2 in-range reads, 1 out-of-range read -> stat_wr=3, stat_rd=2, stat_err=1.
